// File: rtl/ram_access_arbiter_if.sv
// Client request/grant signals plus the RAM-side port bundle for ram_access_arbiter.
// The slave modport is the arbiter's view; master is the clients + RAM side.
interface ram_access_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  iReq0;
    logic                  iReq1;
    logic                  iWrite0;
    logic                  iWrite1;
    logic [ADDR_WIDTH-1:0] iAddr0;
    logic [ADDR_WIDTH-1:0] iAddr1;
    logic [DATA_WIDTH-1:0] iData0;
    logic [DATA_WIDTH-1:0] iData1;
    logic                  oGrant0;
    logic                  oGrant1;
    logic                  oDone0;
    logic                  oDone1;
    logic [DATA_WIDTH-1:0] oReadData;
    logic                  oRamWriteEnable;
    logic [ADDR_WIDTH-1:0] oRamWriteAddress;
    logic [ADDR_WIDTH-1:0] oRamReadAddress;
    logic [DATA_WIDTH-1:0] oRamDataIn;
    logic [DATA_WIDTH-1:0] iRamDataOut;

    modport slave (
        input  iReq0, iReq1, iWrite0, iWrite1, iAddr0, iAddr1, iData0, iData1, iRamDataOut,
        output oGrant0, oGrant1, oDone0, oDone1, oReadData,
               oRamWriteEnable, oRamWriteAddress, oRamReadAddress, oRamDataIn
    );

    modport master (
        output iReq0, iReq1, iWrite0, iWrite1, iAddr0, iAddr1, iData0, iData1, iRamDataOut,
        input  oGrant0, oGrant1, oDone0, oDone1, oReadData,
               oRamWriteEnable, oRamWriteAddress, oRamReadAddress, oRamDataIn
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-read-port RAM between two clients.
// One transaction at a time: IDLE -> ISSUE -> (WAIT, reads only) -> DONE -> IDLE.
module ram_access_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input logic                 Clock,
    input logic                 Reset,
    ram_access_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e                state_q;
    logic                  owner_q;
    logic                  is_write_q;
    logic                  last_served_q;  // 1: client 1 was served most recently
    logic                  grant0_q;
    logic                  grant1_q;
    logic                  done0_q;
    logic                  done1_q;
    logic                  write_enable_q;
    logic [ADDR_WIDTH-1:0] write_address_q;
    logic [ADDR_WIDTH-1:0] read_address_q;
    logic [DATA_WIDTH-1:0] data_in_q;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  pick;

    always_comb begin
        pick = 1'b0;
        if (bus.iReq0 && bus.iReq1) begin
            pick = ~last_served_q;
        end else if (bus.iReq1) begin
            pick = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q         <= StIdle;
            owner_q         <= 1'b0;
            is_write_q      <= 1'b0;
            last_served_q   <= 1'b1;
            grant0_q        <= 1'b0;
            grant1_q        <= 1'b0;
            done0_q         <= 1'b0;
            done1_q         <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            read_address_q  <= '0;
            data_in_q       <= '0;
            read_data_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.iReq0 || bus.iReq1) begin
                        state_q         <= StIssue;
                        owner_q         <= pick;
                        grant0_q        <= ~pick;
                        grant1_q        <= pick;
                        is_write_q      <= pick ? bus.iWrite1 : bus.iWrite0;
                        write_enable_q  <= pick ? bus.iWrite1 : bus.iWrite0;
                        write_address_q <= pick ? bus.iAddr1 : bus.iAddr0;
                        read_address_q  <= pick ? bus.iAddr1 : bus.iAddr0;
                        data_in_q       <= pick ? bus.iData1 : bus.iData0;
                    end
                end
                StIssue: begin
                    write_enable_q <= 1'b0;
                    if (is_write_q) begin
                        state_q       <= StDone;
                        last_served_q <= owner_q;
                        done0_q       <= ~owner_q;
                        done1_q       <= owner_q;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    // Registered RAM output is valid during this cycle
                    read_data_q   <= bus.iRamDataOut;
                    state_q       <= StDone;
                    last_served_q <= owner_q;
                    done0_q       <= ~owner_q;
                    done1_q       <= owner_q;
                end
                StDone: begin
                    state_q  <= StIdle;
                    done0_q  <= 1'b0;
                    done1_q  <= 1'b0;
                    grant0_q <= 1'b0;
                    grant1_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.oGrant0          = grant0_q;
    assign bus.oGrant1          = grant1_q;
    assign bus.oDone0           = done0_q;
    assign bus.oDone1           = done1_q;
    assign bus.oReadData        = read_data_q;
    assign bus.oRamWriteEnable  = write_enable_q;
    assign bus.oRamWriteAddress = write_address_q;
    assign bus.oRamReadAddress  = read_address_q;
    assign bus.oRamDataIn       = data_in_q;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: transaction table plus hand-written sequences
// for simultaneous requests, back-to-back alternation and reset in mid-read.
module tb_ram_access_arbiter;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 Clock = ~Clock;

    ram_access_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

    ram_access_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    // RAM: one write port, one registered read port
    logic [15:0] mem [256];
    logic [15:0] ram_q;
    always @(posedge Clock) begin
        if (bus.oRamWriteEnable) mem[bus.oRamWriteAddress] <= bus.oRamDataIn;
        ram_q <= mem[bus.oRamReadAddress];
    end
    assign bus.iRamDataOut = ram_q;

    typedef struct {
        logic        req0, req1, wr0, wr1;
        logic [7:0]  addr0, addr1;
        logic [15:0] data0, data1;
        int          exp_win;
        int          exp_done;
        int          exp_we;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " grant0"}, bus.oGrant0, 0);
        check({tag, " grant1"}, bus.oGrant1, 0);
        check({tag, " done0"}, bus.oDone0, 0);
        check({tag, " done1"}, bus.oDone1, 0);
        check({tag, " we"}, bus.oRamWriteEnable, 0);
    endtask

    task automatic clear_inputs();
        bus.iReq0 = 0; bus.iReq1 = 0; bus.iWrite0 = 0; bus.iWrite1 = 0;
        bus.iAddr0 = 0; bus.iAddr1 = 0; bus.iData0 = 0; bus.iData1 = 0;
    endtask

    // Issue one table entry from IDLE; requests are dropped and inputs scrambled after E0.
    task automatic run_txn(input int idx, input vec_t v);
        int          done_cyc;
        int          we_cnt;
        int          g_cnt;
        logic [15:0] rd;
        logic [7:0]  w_addr;
        logic [15:0] w_data;
        string       tag;
        tag = $sformatf("vec%0d", idx);
        w_addr = (v.exp_win == 1) ? v.addr1 : v.addr0;
        w_data = (v.exp_win == 1) ? v.data1 : v.data0;
        bus.iReq0 = v.req0; bus.iReq1 = v.req1; bus.iWrite0 = v.wr0; bus.iWrite1 = v.wr1;
        bus.iAddr0 = v.addr0; bus.iAddr1 = v.addr1; bus.iData0 = v.data0; bus.iData1 = v.data1;
        step();
        bus.iReq0 = 0; bus.iReq1 = 0; bus.iWrite0 = ~v.wr0; bus.iWrite1 = ~v.wr1;
        bus.iAddr0 = ~v.addr0; bus.iAddr1 = ~v.addr1; bus.iData0 = ~v.data0; bus.iData1 = ~v.data1;
        done_cyc = 0; we_cnt = 0; g_cnt = 0; rd = '0;
        for (int c = 1; c <= 8 && done_cyc == 0; c++) begin
            if (c == 1) check({tag, " read_addr"}, bus.oRamReadAddress, w_addr);
            check({tag, " loser_grant"}, (v.exp_win == 1) ? bus.oGrant0 : bus.oGrant1, 0);
            check({tag, " loser_done"}, (v.exp_win == 1) ? bus.oDone0 : bus.oDone1, 0);
            if (bus.oRamWriteEnable) begin
                we_cnt++;
                check({tag, " write_addr"}, bus.oRamWriteAddress, w_addr);
                check({tag, " write_data"}, bus.oRamDataIn, w_data);
            end
            if ((v.exp_win == 1) ? bus.oGrant1 : bus.oGrant0) g_cnt++;
            if ((v.exp_win == 1) ? bus.oDone1 : bus.oDone0) begin
                done_cyc = c;
                rd = bus.oReadData;
            end else begin
                step();
            end
        end
        check({tag, " done_cycle"}, done_cyc, v.exp_done);
        check({tag, " we_cycles"}, we_cnt, v.exp_we);
        check({tag, " grant_cycles"}, g_cnt, v.exp_done);
        check({tag, " read_data"}, rd, v.exp_rd);
        step();
        check_idle_outputs({tag, " after"});
        clear_inputs();
    endtask

    initial begin
        //          req0 req1 wr0 wr1 addr0  addr1  data0     data1     win done we rd
        vecs[0] = '{1, 0, 1, 0, 8'h12, 8'h00, 16'hBEEF, 16'h0000, 0, 2, 1, 16'h5555};
        vecs[1] = '{0, 1, 0, 0, 8'h00, 8'h12, 16'h0000, 16'h0000, 1, 3, 0, 16'hBEEF};
        vecs[2] = '{1, 1, 1, 1, 8'h20, 8'h21, 16'hAAAA, 16'hBBBB, 0, 2, 1, 16'hBEEF};
        vecs[3] = '{0, 1, 0, 0, 8'h00, 8'h20, 16'h0000, 16'h0000, 1, 3, 0, 16'hAAAA};
        vecs[4] = '{1, 1, 0, 1, 8'h20, 8'h21, 16'h0000, 16'hBBBB, 0, 3, 0, 16'hAAAA};
        vecs[5] = '{1, 1, 1, 0, 8'hFF, 8'h12, 16'h1234, 16'h0000, 1, 3, 0, 16'hBEEF};
        vecs[6] = '{1, 1, 1, 1, 8'hFF, 8'h00, 16'h1234, 16'h0F0F, 0, 2, 1, 16'hBEEF};
        vecs[7] = '{0, 1, 0, 0, 8'h00, 8'hFF, 16'h0000, 16'h0000, 1, 3, 0, 16'h1234};
        vecs[8] = '{1, 0, 1, 0, 8'h01, 8'h00, 16'h1111, 16'h0000, 0, 2, 1, 16'h1234};
        vecs[9] = '{0, 1, 0, 1, 8'h00, 8'h02, 16'h0000, 16'h2222, 1, 2, 1, 16'h1234};

        clear_inputs();
        Reset = 1;
        step(); step();
        Reset = 0;

        // Idle after reset: everything stays at zero
        for (int c = 0; c < 5; c++) begin
            check_idle_outputs($sformatf("idle%0d", c));
            check("idle waddr", bus.oRamWriteAddress, 0);
            check("idle raddr", bus.oRamReadAddress, 0);
            check("idle din", bus.oRamDataIn, 0);
            check("idle rdata", bus.oReadData, 0);
            step();
        end

        // Simultaneous write (client 0) and read (client 1) right after reset
        bus.iReq0 = 1; bus.iWrite0 = 1; bus.iAddr0 = 8'h05; bus.iData0 = 16'h5555;
        bus.iReq1 = 1; bus.iWrite1 = 0; bus.iAddr1 = 8'h05;
        step();
        bus.iReq0 = 0;
        check("sim issue grant0", bus.oGrant0, 1);
        check("sim issue grant1", bus.oGrant1, 0);
        check("sim issue we", bus.oRamWriteEnable, 1);
        check("sim issue waddr", bus.oRamWriteAddress, 8'h05);
        check("sim issue din", bus.oRamDataIn, 16'h5555);
        step();
        check("sim done0", bus.oDone0, 1);
        check("sim done we", bus.oRamWriteEnable, 0);
        step();
        check_idle_outputs("sim bubble");
        step();
        bus.iReq1 = 0;
        check("sim read grant1", bus.oGrant1, 1);
        check("sim read grant0", bus.oGrant0, 0);
        check("sim read raddr", bus.oRamReadAddress, 8'h05);
        step();
        check("sim wait done1", bus.oDone1, 0);
        step();
        check("sim read done1", bus.oDone1, 1);
        check("sim read data", bus.oReadData, 16'h5555);
        step();
        check_idle_outputs("sim end");
        clear_inputs();

        for (int i = 0; i < 10; i++) run_txn(i, vecs[i]);

        // Both clients hold reads: 4-cycle transactions alternating 0,1,0,1
        bus.iReq0 = 1; bus.iAddr0 = 8'h01;
        bus.iReq1 = 1; bus.iAddr1 = 8'h02;
        for (int c = 1; c <= 16; c++) begin
            int phase;
            int who;
            step();
            phase = (c - 1) % 4;
            who = ((c - 1) / 4) % 2;
            check($sformatf("b2b c%0d grant0", c), bus.oGrant0, (phase < 3 && who == 0));
            check($sformatf("b2b c%0d grant1", c), bus.oGrant1, (phase < 3 && who == 1));
            check($sformatf("b2b c%0d done0", c), bus.oDone0, (phase == 2 && who == 0));
            check($sformatf("b2b c%0d done1", c), bus.oDone1, (phase == 2 && who == 1));
            if (phase == 2)
                check($sformatf("b2b c%0d rdata", c), bus.oReadData,
                      (who == 1) ? 16'h2222 : 16'h1111);
        end
        clear_inputs();
        step();

        // Reset during the WAIT cycle of a read aborts it without a done pulse
        bus.iReq0 = 1; bus.iWrite0 = 0; bus.iAddr0 = 8'h12;
        step();
        clear_inputs();
        check("rst issue grant0", bus.oGrant0, 1);
        step();
        check("rst wait grant0", bus.oGrant0, 1);
        check("rst wait done0", bus.oDone0, 0);
        Reset = 1;
        step();
        Reset = 0;
        check_idle_outputs("rst after");
        check("rst after raddr", bus.oRamReadAddress, 0);
        check("rst after rdata", bus.oReadData, 0);
        for (int c = 0; c < 3; c++) begin
            check("rst no done0", bus.oDone0, 0);
            check("rst no grant0", bus.oGrant0, 0);
            step();
        end
        run_txn(99, '{1, 0, 0, 0, 8'h12, 8'h00, 16'h0000, 16'h0000, 0, 3, 0, 16'hBEEF});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
